shift_seq_ctrl: RTL and testbench
=================================

SHIFT_SEQ_CTRL -- requirements
Module: shift_seq_ctrl

Interface
REQ-001 Parameter: N, default 4, width of the controlled load/store/shift register and data words.
REQ-002 Parameter: CW, default 3, width of the shift-count field; SHALL satisfy 2^CW > N.
REQ-003 Port clk  input  1  single clock; all state SHALL update on posedge clk.
REQ-004 Port clr  input  1  reset, asynchronous, active-low.
REQ-005 Port start  input  1  request pulse, sampled on posedge clk.
REQ-006 Port din  input  N  parallel word to load.
REQ-007 Port dir  input  1  shift direction: 0 = left, 1 = right.
REQ-008 Port cnt  input  CW  number of 1-bit shifts requested.
REQ-009 Port fill  input  1  serial bit shifted in on each shift.
REQ-010 Port abort  input  1  cancel the current operation.
REQ-011 Port reg_out  input  N  current contents of the controlled register.
REQ-012 Port ctrl  output  2  register command: 00 store, 01 parallel load, 10 left shift, 11 right shift.
REQ-013 Port reg_in  output  N  parallel data to the register.
REQ-014 Port ls  output  1  left-shift serial-in bit to the register.
REQ-015 Port rs  output  1  right-shift serial-in bit to the register.
REQ-016 Port busy  output  1  high in every state except IDLE.
REQ-017 Port done  output  1  one-cycle completion strobe.
REQ-018 Port result  output  N  register contents captured at completion.
REQ-019 Port rem  output  CW  shifts still to issue.

Function
REQ-020 The controller SHALL be a Moore FSM with states IDLE, LOAD, SHIFT and DONE; ctrl, reg_in, ls, rs, busy, done and rem SHALL be registered or decoded from state only.
REQ-021 IDLE: ctrl=00; start=1 SHALL latch din, dir, fill and cnt_eff = min(cnt, N), then move to LOAD.
REQ-022 LOAD: exactly one cycle with ctrl=01 and reg_in=latched din; next state SHALL be SHIFT if cnt_eff>0, else DONE.
REQ-023 SHIFT: ctrl SHALL be 10 (dir=0) or 11 (dir=1); rem SHALL decrement once per cycle; the state SHALL exit to DONE after exactly cnt_eff SHIFT cycles.
REQ-024 In every state, ls=rs=latched fill.
REQ-025 DONE: exactly one cycle with ctrl=00 and done=1; result SHALL capture reg_out on the DONE->IDLE edge; next state SHALL be IDLE.
REQ-026 Latency: the start edge to done=1 SHALL take cnt_eff+2 cycles; busy SHALL be high for cnt_eff+2 cycles.
REQ-027 start while busy=1 SHALL be ignored, with no queuing.
REQ-028 start in the same cycle that DONE returns to IDLE SHALL be ignored; a new start is accepted only when sampled in IDLE.
REQ-029 abort=1 in LOAD, SHIFT or DONE SHALL force IDLE on the next edge, with ctrl=00 from that cycle; done SHALL stay 0 and result SHALL keep its prior value.
REQ-030 abort takes precedence over every other transition; abort in IDLE SHALL be ignored and SHALL NOT block start.
REQ-031 cnt > N SHALL saturate to N shifts; rem SHALL reflect the saturated value.
REQ-032 The register SHALL be held at store (00) whenever the controller is not loading or shifting.

Reset
REQ-033 clr=0 SHALL immediately, without a clock, force state=IDLE, ctrl=00, reg_in=0, ls=rs=0, busy=0, done=0, result=0 and rem=0.
REQ-034 Deasserting clr mid-operation SHALL leave the FSM in IDLE; the aborted request SHALL NOT resume.

Verification
REQ-035 N=4: din=1011, dir=0, cnt=2, fill=0 -> LOAD, then 2 cycles of ctrl=10, done at cycle 4, result=1100.
REQ-036 din=1011, dir=1, cnt=1, fill=1 -> one ctrl=11 cycle, result=1101, done pulse of exactly 1 cycle.
REQ-037 cnt=0, din=0110 -> LOAD then DONE, done at cycle 2, result=0110, no shift commands issued.
REQ-038 cnt=7 with N=4 -> rem starts at 4, 4 shift cycles; din=1111, dir=0, fill=0 -> result=0000.
REQ-039 abort asserted during the 2nd SHIFT cycle -> IDLE next edge, done stays 0, result unchanged; start pulses while busy are ignored.
REQ-040 clr pulsed low mid-SHIFT between clock edges -> all outputs zero immediately; after release, stays IDLE until the next start.

Source files
------------

// File: rtl/shift_seq_ctrl.sv
// Moore-style sequencer that drives a load/store/shift register through one load-and-shift
// operation per start request, then reports the register contents when the operation completes.
module shift_seq_ctrl #(
  parameter int unsigned N  = 4,
  parameter int unsigned CW = 3
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          start,
  input  logic [N-1:0]  din,
  input  logic          dir,
  input  logic [CW-1:0] cnt,
  input  logic          fill,
  input  logic          abort,
  input  logic [N-1:0]  reg_out,
  output logic [1:0]    ctrl,
  output logic [N-1:0]  reg_in,
  output logic          ls,
  output logic          rs,
  output logic          busy,
  output logic          done,
  output logic [N-1:0]  result,
  output logic [CW-1:0] rem
);

  typedef enum logic [1:0] {StIdle, StLoad, StShift, StDone} state_e;

  localparam logic [CW-1:0] CntMax = CW'(N);

  localparam logic [1:0] CtrlStore = 2'b00;
  localparam logic [1:0] CtrlLoad  = 2'b01;

  state_e        state_q, state_d;
  logic [N-1:0]  din_q, din_d;
  logic          dir_q, dir_d;
  logic          fill_q, fill_d;
  logic [CW-1:0] rem_q, rem_d;
  logic [N-1:0]  result_q, result_d;
  logic [CW-1:0] cnt_eff;

  // Requests longer than the register saturate to a full-width shift.
  assign cnt_eff = (cnt > CntMax) ? CntMax : cnt;

  always_comb begin
    state_d  = state_q;
    din_d    = din_q;
    dir_d    = dir_q;
    fill_d   = fill_q;
    rem_d    = rem_q;
    result_d = result_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StLoad;
          din_d   = din;
          dir_d   = dir;
          fill_d  = fill;
          rem_d   = cnt_eff;
        end
      end
      StLoad: begin
        state_d = (rem_q != '0) ? StShift : StDone;
      end
      StShift: begin
        rem_d = rem_q - CW'(1);
        if (rem_q <= CW'(1)) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d  = StIdle;
        result_d = reg_out;
      end
      default: state_d = StIdle;
    endcase
    // Abort wins over every other transition but has no effect while idle.
    if (abort && (state_q != StIdle)) begin
      state_d  = StIdle;
      rem_d    = '0;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q  <= StIdle;
      din_q    <= '0;
      dir_q    <= 1'b0;
      fill_q   <= 1'b0;
      rem_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      din_q    <= din_d;
      dir_q    <= dir_d;
      fill_q   <= fill_d;
      rem_q    <= rem_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    ctrl = CtrlStore;
    unique case (state_q)
      StLoad:  ctrl = CtrlLoad;
      StShift: ctrl = {1'b1, dir_q};
      default: ctrl = CtrlStore;
    endcase
  end

  assign reg_in = din_q;
  assign ls     = fill_q;
  assign rs     = fill_q;
  assign busy   = (state_q != StIdle);
  assign done   = (state_q == StDone);
  assign result = result_q;
  assign rem    = rem_q;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Self-checking bench for shift_seq_ctrl: a behavioural register follows ctrl, and a scoreboard
// of expected results is compared against result after each done strobe.
module tb_shift_seq_ctrl;

  localparam int unsigned N  = 4;
  localparam int unsigned CW = 3;

  logic          clk;
  logic          clr;
  logic          start;
  logic [N-1:0]  din;
  logic          dir;
  logic [CW-1:0] cnt;
  logic          fill;
  logic          abort;
  logic [N-1:0]  reg_out;
  logic [1:0]    ctrl;
  logic [N-1:0]  reg_in;
  logic          ls;
  logic          rs;
  logic          busy;
  logic          done;
  logic [N-1:0]  result;
  logic [CW-1:0] rem;

  int checks = 0;
  int passed = 0;

  logic [N-1:0] exp_q[$];
  logic [N-1:0] mon_exp;
  logic         mon_pend = 1'b0;

  shift_seq_ctrl #(.N(N), .CW(CW)) dut (
    .clk     (clk),
    .clr     (clr),
    .start   (start),
    .din     (din),
    .dir     (dir),
    .cnt     (cnt),
    .fill    (fill),
    .abort   (abort),
    .reg_out (reg_out),
    .ctrl    (ctrl),
    .reg_in  (reg_in),
    .ls      (ls),
    .rs      (rs),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .rem     (rem)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Controlled register: store / load / shift-left / shift-right.
  always @(posedge clk or negedge clr) begin
    if (!clr) begin
      reg_out <= '0;
    end else begin
      case (ctrl)
        2'b01:   reg_out <= reg_in;
        2'b10:   reg_out <= {reg_out[N-2:0], ls};
        2'b11:   reg_out <= {rs, reg_out[N-1:1]};
        default: reg_out <= reg_out;
      endcase
    end
  end

  function automatic logic [N-1:0] model(input logic [N-1:0] d, input logic dr,
                                         input logic [CW-1:0] c, input logic f);
    logic [N-1:0] r;
    int           eff;
    r   = d;
    eff = (int'(c) > N) ? N : int'(c);
    for (int i = 0; i < eff; i++) begin
      r = dr ? {f, r[N-1:1]} : {r[N-2:0], f};
    end
    return r;
  endfunction

  // Scoreboard: pop on done, compare result once it has been captured on the next edge.
  always @(negedge clk) begin
    if (mon_pend) begin
      mon_pend = 1'b0;
      checks++;
      if (result !== mon_exp) $display("FAIL result: got %b expected %b", result, mon_exp);
      else passed++;
    end
    if (done === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_done: got done=1 expected no completion");
      end else begin
        mon_exp  = exp_q.pop_front();
        mon_pend = 1'b1;
      end
    end
  end

  task automatic start_op(input logic [N-1:0] d, input logic dr, input logic [CW-1:0] c,
                          input logic f, input logic ab, input logic expect_done);
    @(negedge clk);
    start = 1'b1;
    din   = d;
    dir   = dr;
    cnt   = c;
    fill  = f;
    abort = ab;
    if (expect_done) exp_q.push_back(model(d, dr, c, f));
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
  endtask

  // Full operation with cycle-by-cycle checks of ctrl, rem and the done/busy timing.
  task automatic op_sequence(input string name, input logic [N-1:0] d, input logic dr,
                             input logic [CW-1:0] c, input logic f);
    int eff;
    eff = (int'(c) > N) ? N : int'(c);
    start_op(d, dr, c, f, 1'b0, 1'b1);
    checks++;
    if ({ctrl, reg_in, rem, busy, done, ls, rs} !== {2'b01, d, CW'(eff), 1'b1, 1'b0, f, f})
      $display("FAIL %s_load: got ctrl=%b reg_in=%b rem=%0d busy=%b done=%b ls=%b rs=%b expected ctrl=01 reg_in=%b rem=%0d busy=1 done=0 ls=rs=%b",
               name, ctrl, reg_in, rem, busy, done, ls, rs, d, eff, f);
    else passed++;
    for (int k = 0; k < eff; k++) begin
      @(negedge clk);
      checks++;
      if ({ctrl, rem, done} !== {1'b1, dr, CW'(eff - k), 1'b0})
        $display("FAIL %s_shift%0d: got ctrl=%b rem=%0d done=%b expected ctrl=1%b rem=%0d done=0",
                 name, k, ctrl, rem, done, dr, eff - k);
      else passed++;
    end
    @(negedge clk);
    checks++;
    if ({ctrl, done, busy, rem} !== {2'b00, 1'b1, 1'b1, CW'(0)})
      $display("FAIL %s_done: got ctrl=%b done=%b busy=%b rem=%0d expected ctrl=00 done=1 busy=1 rem=0",
               name, ctrl, done, busy, rem);
    else passed++;
    @(negedge clk);
    checks++;
    if ({done, busy, ctrl} !== {1'b0, 1'b0, 2'b00})
      $display("FAIL %s_idle: got done=%b busy=%b ctrl=%b expected done=0 busy=0 ctrl=00",
               name, done, busy, ctrl);
    else passed++;
  endtask

  task automatic test_reset();
    clr = 1'b0; start = 1'b0; din = '0; dir = 1'b0; cnt = '0; fill = 1'b0; abort = 1'b0;
    #7;
    checks++;
    if ({ctrl, reg_in, ls, rs, busy, done, result, rem} !== '0)
      $display("FAIL reset: got ctrl=%b reg_in=%b ls=%b rs=%b busy=%b done=%b result=%b rem=%0d expected all zero",
               ctrl, reg_in, ls, rs, busy, done, result, rem);
    else passed++;
    @(negedge clk);
    clr = 1'b1;
  endtask

  task automatic test_left_shift();
    op_sequence("left", 4'b1011, 1'b0, 3'd2, 1'b0);
  endtask

  task automatic test_right_shift();
    op_sequence("right", 4'b1011, 1'b1, 3'd1, 1'b1);
  endtask

  task automatic test_abort();
    start_op(4'b1011, 1'b0, 3'd3, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    // Start while busy must be dropped, not queued.
    start = 1'b1; din = 4'b0001; cnt = 3'd0;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if ({ctrl, rem} !== {2'b10, 3'd2})
      $display("FAIL abort_pre: got ctrl=%b rem=%0d expected ctrl=10 rem=2", ctrl, rem);
    else passed++;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if ({busy, ctrl, done, result} !== {1'b0, 2'b00, 1'b0, 4'b1101})
      $display("FAIL abort_idle: got busy=%b ctrl=%b done=%b result=%b expected busy=0 ctrl=00 done=0 result=1101",
               busy, ctrl, done, result);
    else passed++;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if ({busy, done, result} !== {1'b0, 1'b0, 4'b1101})
        $display("FAIL abort_stay%0d: got busy=%b done=%b result=%b expected busy=0 done=0 result=1101",
                 k, busy, done, result);
      else passed++;
    end
  endtask

  task automatic test_zero_cnt();
    op_sequence("zero", 4'b0110, 1'b0, 3'd0, 1'b1);
  endtask

  task automatic test_back_to_back();
    start_op(4'b1001, 1'b1, 3'd0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    checks++;
    if (done !== 1'b1) $display("FAIL b2b_done: got done=%b expected 1", done);
    else passed++;
    // Sampled on the DONE->IDLE edge: must be ignored.
    start = 1'b1; din = 4'b1111; cnt = 3'd1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if ({busy, ctrl} !== {1'b0, 2'b00})
      $display("FAIL b2b_ignored: got busy=%b ctrl=%b expected busy=0 ctrl=00", busy, ctrl);
    else passed++;
    op_sequence("b2b_next", 4'b0011, 1'b0, 3'd1, 1'b1);
  endtask

  task automatic test_saturate();
    op_sequence("sat", 4'b1111, 1'b0, 3'd7, 1'b0);
  endtask

  task automatic test_abort_idle_start();
    // Abort high together with start while idle must not block the request.
    start_op(4'b0101, 1'b1, 3'd2, 1'b0, 1'b1, 1'b1);
    checks++;
    if ({busy, ctrl} !== {1'b1, 2'b01})
      $display("FAIL abort_idle_start: got busy=%b ctrl=%b expected busy=1 ctrl=01", busy, ctrl);
    else passed++;
    repeat (4) @(negedge clk);
    checks++;
    if (busy !== 1'b0) $display("FAIL abort_idle_end: got busy=%b expected 0", busy);
    else passed++;
  endtask

  task automatic test_clr_mid();
    start_op(4'b1011, 1'b1, 3'd3, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    checks++;
    if (ctrl !== 2'b11) $display("FAIL clr_pre: got ctrl=%b expected 11", ctrl);
    else passed++;
    #2 clr = 1'b0;
    #1;
    checks++;
    if ({ctrl, reg_in, ls, rs, busy, done, result, rem} !== '0)
      $display("FAIL clr_async: got ctrl=%b reg_in=%b ls=%b rs=%b busy=%b done=%b result=%b rem=%0d expected all zero",
               ctrl, reg_in, ls, rs, busy, done, result, rem);
    else passed++;
    @(negedge clk);
    clr = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if ({busy, ctrl, done} !== {1'b0, 2'b00, 1'b0})
        $display("FAIL clr_stay%0d: got busy=%b ctrl=%b done=%b expected busy=0 ctrl=00 done=0",
                 k, busy, ctrl, done);
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_left_shift();
    test_right_shift();
    test_abort();
    test_zero_cnt();
    test_back_to_back();
    test_saturate();
    test_abort_idle_start();
    test_clr_mid();
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) $display("FAIL missing_done: got %0d pending expected 0", exp_q.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish before 100000");
    $fatal(1, "timeout");
  end

endmodule
